// File: rtl/ddr3_arb_pkg.sv
// ddr3_arb_pkg
//   Shared definitions for the DDR3 port arbiter: FSM state codes, MIG
//   command codes, per-beat address step and the read-tag entry layout.
//   No ports.
package ddr3_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARB   = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_READ  = 2'd3;

  localparam logic [2:0] CMD_WR = 3'd0;
  localparam logic [2:0] CMD_RD = 3'd1;

  // One MIG user beat covers 8 DRAM column addresses (BL8).
  localparam int BEAT_STEP = 8;

  // Tag fields are sized for the largest supported configuration
  // (NPORT <= 8, LEN_W <= 16).
  localparam int TAG_PORT_W = 3;
  localparam int TAG_LEN_W  = 16;

  typedef struct packed {
    logic [TAG_PORT_W-1:0] port;
    logic [TAG_LEN_W-1:0]  remaining;
  } tag_entry_t;

endpackage

// File: rtl/ddr3_rd_tag_fifo.sv
// ddr3_rd_tag_fifo
//   In-order FIFO of outstanding read bursts. Each entry holds the
//   originating port and the number of read beats still to come back.
//   A read-return beat decrements the head; the head is popped on its
//   last beat. Push and beat in the same cycle are both honoured.
// Ports:
//   ui_clk, ui_clk_sync_rst   clock, async active-high reset
//   push, push_entry          enqueue a new read burst (ignored when full)
//   beat                      one read-return beat (ignored when empty)
//   head_port                 port id of the head entry
//   full, empty               occupancy flags
module ddr3_rd_tag_fifo
  import ddr3_arb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                  ui_clk,
  input  logic                  ui_clk_sync_rst,
  input  logic                  push,
  input  tag_entry_t            push_entry,
  input  logic                  beat,
  output logic [TAG_PORT_W-1:0] head_port,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);

  tag_entry_t mem [DEPTH];
  tag_entry_t head;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_beat;
  logic        do_pop;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head      = mem[rd_ptr[AW-1:0]];
  assign head_port = head.port;

  assign do_push = push && !full;
  assign do_beat = beat && !empty;
  assign do_pop  = do_beat && (head.remaining == TAG_LEN_W'(1));

  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers.
  // The push slot never aliases the head while the FIFO is non-empty.
  always_ff @(posedge ui_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_entry;
    if (do_beat && !do_pop) mem[rd_ptr[AW-1:0]].remaining <= head.remaining - 1'b1;
  end

endmodule

// File: rtl/ddr3_port_arbiter.sv
// ddr3_port_arbiter
//   Shares one MIG user interface between NPORT burst requesters.
//   Round-robin grant, MIG command / write-data sequencing, and in-order
//   routing of read-return beats back to the requesting port.
// Ports:
//   ui_clk, ui_clk_sync_rst       clock, async active-high reset
//   init_calib_complete           MIG calibration done
//   req/req_rd/req_addr/req_len   per-port burst request (flattened)
//   wr_data                       per-port write FIFO show-ahead data
//   grant/done/wr_pop/rd_valid    per-port one-hot strobes
//   rd_data                       read data passthrough
//   busy                          high while a burst is being issued
//   app_*                         MIG user interface
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | waiting for MIG calibration
// ST_ARB   | round-robin scan; grant and latch the winning burst
// ST_WRITE | issuing write command + data beats for the active port
// ST_READ  | issuing read command beats for the active port
module ddr3_port_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter int NPORT     = 4,
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 128,
  parameter int LEN_W     = 8,
  parameter int TAG_DEPTH = 8
) (
  input  logic                    ui_clk,
  input  logic                    ui_clk_sync_rst,
  input  logic                    init_calib_complete,
  input  logic [NPORT-1:0]        req,
  input  logic [NPORT-1:0]        req_rd,
  input  logic [NPORT*ADDR_W-1:0] req_addr,
  input  logic [NPORT*LEN_W-1:0]  req_len,
  input  logic [NPORT*DATA_W-1:0] wr_data,
  output logic [NPORT-1:0]        grant,
  output logic [NPORT-1:0]        done,
  output logic [NPORT-1:0]        wr_pop,
  output logic [NPORT-1:0]        rd_valid,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    busy,
  input  logic                    app_rdy,
  input  logic                    app_wdf_rdy,
  input  logic                    app_rd_data_valid,
  input  logic [DATA_W-1:0]       app_rd_data,
  output logic                    app_en,
  output logic                    app_wdf_wren,
  output logic                    app_wdf_end,
  output logic [2:0]              app_cmd,
  output logic [ADDR_W-1:0]       app_addr,
  output logic [DATA_W-1:0]       app_wdf_data
);

  localparam int PW = $clog2(NPORT);

  logic [1:0]        state;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     act_port;
  logic [ADDR_W-1:0] act_addr;
  logic [LEN_W-1:0]  act_len;
  logic [LEN_W-1:0]  bc;
  logic              rd_err;

  logic              win_found;
  logic [PW-1:0]     win;
  logic [PW-1:0]     scan_idx;
  logic [LEN_W-1:0]  win_len;
  logic [ADDR_W-1:0] win_addr;
  logic              win_rd;
  logic              arb_take;
  logic              wr_accept;
  logic              rd_accept;
  logic              beat_acc;
  logic              last_beat;

  logic                  tag_push;
  tag_entry_t            tag_entry;
  logic [TAG_PORT_W-1:0] tag_head_port;
  logic                  tag_full;
  logic                  tag_empty;

  // First eligible port at or after ptr. A read needs a free tag slot,
  // so a full tag FIFO lets writes from other ports through.
  always_comb begin
    win_found = 1'b0;
    win       = '0;
    scan_idx  = '0;
    for (int i = 0; i < NPORT; i++) begin
      scan_idx = PW'((int'(ptr) + i) % NPORT);
      if (!win_found && req[scan_idx] && (!req_rd[scan_idx] || !tag_full)) begin
        win_found = 1'b1;
        win       = scan_idx;
      end
    end
  end

  assign win_len  = req_len[int'(win)*LEN_W +: LEN_W];
  assign win_addr = req_addr[int'(win)*ADDR_W +: ADDR_W];
  assign win_rd   = req_rd[win];
  assign arb_take = (state == ST_ARB) && win_found;

  assign wr_accept = (state == ST_WRITE) && app_rdy && app_wdf_rdy;
  assign rd_accept = (state == ST_READ) && app_rdy;
  assign beat_acc  = wr_accept || rd_accept;
  assign last_beat = (bc == act_len - 1'b1);

  assign tag_push  = arb_take && win_rd && (win_len != '0);
  assign tag_entry = '{port: TAG_PORT_W'(win), remaining: TAG_LEN_W'(win_len)};

  ddr3_rd_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .ui_clk          (ui_clk),
    .ui_clk_sync_rst (ui_clk_sync_rst),
    .push            (tag_push),
    .push_entry      (tag_entry),
    .beat            (app_rd_data_valid),
    .head_port       (tag_head_port),
    .full            (tag_full),
    .empty           (tag_empty)
  );

  always_comb begin
    grant        = '0;
    done         = '0;
    wr_pop       = '0;
    rd_valid     = '0;
    app_en       = beat_acc;
    app_wdf_wren = wr_accept;
    app_wdf_end  = wr_accept;
    app_cmd      = CMD_WR;
    app_addr     = '0;
    app_wdf_data = '0;
    busy         = (state == ST_WRITE) || (state == ST_READ);
    if (arb_take) begin
      grant = NPORT'(1) << win;
      if (win_len == '0) done = NPORT'(1) << win;
    end
    if (beat_acc && last_beat) done = NPORT'(1) << act_port;
    if (wr_accept) wr_pop = NPORT'(1) << act_port;
    if (state == ST_READ) app_cmd = CMD_RD;
    if (busy) app_addr = act_addr + ADDR_W'(BEAT_STEP) * ADDR_W'(bc);
    if (state == ST_WRITE) app_wdf_data = wr_data[int'(act_port)*DATA_W +: DATA_W];
    // Beats arriving with no outstanding read are dropped.
    if (app_rd_data_valid && !tag_empty) rd_valid = NPORT'(1) << tag_head_port;
  end

  assign rd_data = app_rd_data;

  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      act_port <= '0;
      act_addr <= '0;
      act_len  <= '0;
      bc       <= '0;
      rd_err   <= 1'b0;
    end else begin
      if (app_rd_data_valid && tag_empty) rd_err <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (init_calib_complete) state <= ST_ARB;
        end
        ST_ARB: begin
          if (arb_take) begin
            ptr      <= (win == PW'(NPORT - 1)) ? '0 : win + 1'b1;
            act_port <= win;
            act_addr <= win_addr;
            act_len  <= win_len;
            bc       <= '0;
            if (win_len != '0) state <= win_rd ? ST_READ : ST_WRITE;
          end
        end
        default: begin
          if (beat_acc) begin
            bc <= bc + 1'b1;
            if (last_beat) state <= ST_ARB;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
module tb_ddr3_port_arbiter;
  import ddr3_arb_pkg::*;

  localparam int NPORT     = 4;
  localparam int ADDR_W    = 28;
  localparam int DATA_W    = 128;
  localparam int LEN_W     = 8;
  localparam int TAG_DEPTH = 8;

  logic                    ui_clk;
  logic                    ui_clk_sync_rst;
  logic                    init_calib_complete;
  logic [NPORT-1:0]        req;
  logic [NPORT-1:0]        req_rd;
  logic [NPORT*ADDR_W-1:0] req_addr;
  logic [NPORT*LEN_W-1:0]  req_len;
  logic [NPORT*DATA_W-1:0] wr_data;
  logic [NPORT-1:0]        grant;
  logic [NPORT-1:0]        done;
  logic [NPORT-1:0]        wr_pop;
  logic [NPORT-1:0]        rd_valid;
  logic [DATA_W-1:0]       rd_data;
  logic                    busy;
  logic                    app_rdy;
  logic                    app_wdf_rdy;
  logic                    app_rd_data_valid;
  logic [DATA_W-1:0]       app_rd_data;
  logic                    app_en;
  logic                    app_wdf_wren;
  logic                    app_wdf_end;
  logic [2:0]              app_cmd;
  logic [ADDR_W-1:0]       app_addr;
  logic [DATA_W-1:0]       app_wdf_data;

  int checks = 0;
  int errors = 0;

  logic rdy_pat [5];
  int   rdy_addr [5];
  int   ret_port [5];

  ddr3_port_arbiter #(
    .NPORT (NPORT), .ADDR_W (ADDR_W), .DATA_W (DATA_W),
    .LEN_W (LEN_W), .TAG_DEPTH (TAG_DEPTH)
  ) dut (
    .ui_clk              (ui_clk),
    .ui_clk_sync_rst     (ui_clk_sync_rst),
    .init_calib_complete (init_calib_complete),
    .req                 (req),
    .req_rd              (req_rd),
    .req_addr            (req_addr),
    .req_len             (req_len),
    .wr_data             (wr_data),
    .grant               (grant),
    .done                (done),
    .wr_pop              (wr_pop),
    .rd_valid            (rd_valid),
    .rd_data             (rd_data),
    .busy                (busy),
    .app_rdy             (app_rdy),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data_valid   (app_rd_data_valid),
    .app_rd_data         (app_rd_data),
    .app_en              (app_en),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_cmd             (app_cmd),
    .app_addr            (app_addr),
    .app_wdf_data        (app_wdf_data)
  );

  initial ui_clk = 1'b0;
  always #5 ui_clk = ~ui_clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge ui_clk);
    #2;
  endtask

  task automatic set_port(input int p, input logic rd, input logic [ADDR_W-1:0] addr,
                          input logic [LEN_W-1:0] len);
    req_rd[p]                      = rd;
    req_addr[p*ADDR_W +: ADDR_W]   = addr;
    req_len[p*LEN_W +: LEN_W]      = len;
  endtask

  initial begin
    ui_clk_sync_rst     = 1'b1;
    init_calib_complete = 1'b0;
    req                 = '0;
    req_rd              = '0;
    req_addr            = '0;
    req_len             = '0;
    wr_data             = {128'hD3, 128'hD2, 128'hD1, 128'hD0};
    app_rdy             = 1'b1;
    app_wdf_rdy         = 1'b1;
    app_rd_data_valid   = 1'b0;
    app_rd_data         = '0;
    rdy_pat  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    rdy_addr = '{'h200, 'h208, 'h208, 'h210, 'h210};
    ret_port = '{1, 1, 2, 2, 2};

    // Reset state
    repeat (3) cyc();
    chk("rst_app_en", app_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_cmd", app_cmd, 0);
    chk("rst_state", dut.state, ST_IDLE);

    // Held in IDLE while calibration is pending
    ui_clk_sync_rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("calib_wait_en", app_en, 0);
      chk("calib_wait_state", dut.state, ST_IDLE);
    end
    init_calib_complete = 1'b1;
    cyc();
    chk("arb_entry", dut.state, ST_ARB);

    // Port-0 write, len 4 at 0x100
    set_port(0, 1'b0, 'h100, 4);
    req = 4'b0001;
    #1;
    chk("w4_grant", grant, 4'b0001);
    chk("w4_grant_done", done, 0);
    cyc();
    req = '0;
    for (int b = 0; b < 4; b++) begin
      chk("w4_en", app_en, 1);
      chk("w4_addr", app_addr, 'h100 + 8*b);
      chk("w4_pop", wr_pop, 4'b0001);
      chk("w4_wend", {app_wdf_wren, app_wdf_end}, 2'b11);
      chk("w4_data", app_wdf_data, 'hD0);
      chk("w4_cmd", app_cmd, CMD_WR);
      chk("w4_done", done, (b == 3) ? 4'b0001 : 4'b0000);
      cyc();
    end
    chk("w4_back_arb", dut.state, ST_ARB);
    chk("w4_idle_busy", busy, 0);

    // Reset asserted at beat 2 of a 4-beat write
    set_port(0, 1'b0, 'h400, 4);
    req = 4'b0001;
    #1;
    chk("rw_grant", grant, 4'b0001);
    cyc();
    req = '0;
    chk("rw_beat1_addr", app_addr, 'h400);
    cyc();
    chk("rw_beat2_addr", app_addr, 'h408);
    ui_clk_sync_rst     = 1'b1;
    init_calib_complete = 1'b0;
    #1;
    chk("rw_en", app_en, 0);
    chk("rw_pop", wr_pop, 0);
    chk("rw_done", done, 0);
    chk("rw_busy", busy, 0);
    chk("rw_addr", app_addr, 0);
    chk("rw_wdata", app_wdf_data, 0);
    cyc();
    chk("rw_done_later", done, 0);
    cyc();
    ui_clk_sync_rst = 1'b0;
    cyc();
    chk("rw_idle", dut.state, ST_IDLE);
    init_calib_complete = 1'b1;
    cyc();
    chk("rw_rearb", dut.state, ST_ARB);

    // Round robin: all ports write len 2, order 0,1,2,3,0
    for (int p = 0; p < NPORT; p++) set_port(p, 1'b0, ADDR_W'(p * 'h1000), 2);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_grant", grant, 4'b0001 << (k % 4));
      cyc();
      chk("rr_b0_pop", wr_pop, 4'b0001 << (k % 4));
      chk("rr_b0_addr", app_addr, (k % 4) * 'h1000);
      chk("rr_b0_done", done, 0);
      chk("rr_b0_data", app_wdf_data, 'hD0 + (k % 4));
      cyc();
      chk("rr_b1_pop", wr_pop, 4'b0001 << (k % 4));
      chk("rr_b1_addr", app_addr, (k % 4) * 'h1000 + 8);
      chk("rr_b1_done", done, 4'b0001 << (k % 4));
      cyc();
    end
    req = '0;
    #1;
    chk("rr_quiet", grant, 0);

    // Read len 3 on port 2 with app_rdy toggling
    set_port(2, 1'b1, 'h200, 3);
    req = 4'b0100;
    #1;
    chk("rt_grant", grant, 4'b0100);
    cyc();
    req = '0;
    for (int i = 0; i < 5; i++) begin
      app_rdy = rdy_pat[i];
      #1;
      chk("rt_en", app_en, rdy_pat[i]);
      chk("rt_addr", app_addr, rdy_addr[i]);
      chk("rt_cmd", app_cmd, CMD_RD);
      chk("rt_wren", app_wdf_wren, 0);
      chk("rt_done", done, (i == 4) ? 4'b0100 : 4'b0000);
      cyc();
    end
    app_rdy = 1'b1;
    chk("rt_back_arb", dut.state, ST_ARB);
    for (int i = 0; i < 3; i++) begin
      app_rd_data_valid = 1'b1;
      app_rd_data       = DATA_W'('hE0 + i);
      #1;
      chk("rt_ret_valid", rd_valid, 4'b0100);
      chk("rt_ret_data", rd_data, 'hE0 + i);
      cyc();
    end
    app_rd_data_valid = 1'b0;
    #1;
    chk("rt_tag_empty", dut.tag_empty, 1);

    // Port 1 read len 2, then port 2 read len 3, data returned afterwards
    set_port(1, 1'b1, 'h300, 2);
    req = 4'b0010;
    #1;
    chk("r2_grant", grant, 4'b0010);
    cyc();
    req = '0;
    chk("r2_b0_addr", app_addr, 'h300);
    chk("r2_b0_done", done, 0);
    cyc();
    chk("r2_b1_addr", app_addr, 'h308);
    chk("r2_b1_done", done, 4'b0010);
    cyc();
    set_port(2, 1'b1, 'h500, 3);
    req = 4'b0100;
    #1;
    chk("r3_grant", grant, 4'b0100);
    cyc();
    req = '0;
    for (int b = 0; b < 3; b++) begin
      chk("r3_addr", app_addr, 'h500 + 8*b);
      chk("r3_done", done, (b == 2) ? 4'b0100 : 4'b0000);
      cyc();
    end
    for (int i = 0; i < 5; i++) begin
      app_rd_data_valid = 1'b1;
      app_rd_data       = DATA_W'('hC0 + i);
      #1;
      chk("ret_valid", rd_valid, 4'b0001 << ret_port[i]);
      cyc();
    end
    app_rd_data_valid = 1'b0;
    #1;
    chk("ret_tag_empty", dut.tag_empty, 1);
    chk("ret_no_err", dut.rd_err, 0);
    app_rd_data_valid = 1'b1;
    #1;
    chk("orphan_valid", rd_valid, 0);
    cyc();
    app_rd_data_valid = 1'b0;
    chk("orphan_err", dut.rd_err, 1);

    // Nine len-1 reads with no return data; the ninth is blocked
    set_port(0, 1'b1, 'h600, 1);
    req = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("fill_grant", grant, 4'b0001);
      cyc();
      chk("fill_done", done, 4'b0001);
      chk("fill_addr", app_addr, 'h600);
      cyc();
    end
    #1;
    chk("ninth_blocked", grant, 0);
    chk("tag_full", dut.tag_full, 1);
    cyc();
    chk("ninth_still_blocked", grant, 0);
    chk("ninth_state", dut.state, ST_ARB);
    set_port(3, 1'b0, 'h700, 1);
    req = 4'b1001;
    #1;
    chk("p3_write_grant", grant, 4'b1000);
    cyc();
    req = '0;
    chk("p3_pop", wr_pop, 4'b1000);
    chk("p3_done", done, 4'b1000);
    chk("p3_addr", app_addr, 'h700);
    chk("p3_data", app_wdf_data, 'hD3);
    cyc();
    app_rd_data_valid = 1'b1;
    #1;
    chk("drain_valid", rd_valid, 4'b0001);
    cyc();
    app_rd_data_valid = 1'b0;
    chk("drain_not_full", dut.tag_full, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
